// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants: load funct3 codes, writeback select, default widths.
// No logic; pure definitions.
// Imported by the writeback stage and any load-forwarding logic.
package wb_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_LD  = 1'b1;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

endpackage

// File: rtl/wb_regfile_if.sv
// Bundle of WB-stage inputs, decode read ports and status outputs.
// Master is the pipeline side, slave is the writeback/register-file block.
// Purely combinational signal grouping; no handshake beyond wb_valid.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) ();

  logic              wb_valid;
  logic              wb_we;
  logic              wb_sel;
  logic [2:0]        wb_funct3;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] alu_out_in;
  logic [DATA_W-1:0] ld_data_in;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_commit;
  logic              wb_err;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output wb_valid, wb_we, wb_sel, wb_funct3, wb_rd, alu_out_in, ld_data_in,
           rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, wb_commit, wb_err, retire_cnt
  );

  modport slave (
    input  wb_valid, wb_we, wb_sel, wb_funct3, wb_rd, alu_out_in, ld_data_in,
           rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, wb_commit, wb_err, retire_cnt
  );

endinterface

// File: rtl/wb_regfile_load_align.sv
// Load aligner: picks byte/halfword/word at the byte offset and sign/zero extends.
// Latency: combinational.
// Backpressure: none; flags misaligned offsets and unknown funct3 via err.
module wb_regfile_load_align
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] ld_data,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Little-endian lanes; halfword uses off[1] only, off[0] must be zero.
  assign byte_v = ld_data[{off, 3'b000} +: 8];
  assign half_v = ld_data[{off[1], 4'b0000} +: 16];

  // Extension and legality per load width.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      F3_LBU: data = {{(DATA_W-8){1'b0}}, byte_v};
      F3_LH: begin
        data = {{(DATA_W-16){half_v[15]}}, half_v};
        err  = off[0];
      end
      F3_LHU: begin
        data = {{(DATA_W-16){1'b0}}, half_v};
        err  = off[0];
      end
      F3_LW: begin
        data = ld_data;
        err  = (off != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback select + 32-entry register file (x0 = 0) with bypassed read ports and retire counter.
// Latency: reads/wb_data combinational; writes land on the next rising edge.
// Backpressure: none; every valid WB instruction is consumed each cycle.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] ld_aligned;
  logic              ld_err;
  logic [DATA_W-1:0] wb_data_c;
  logic              err_c;
  logic              commit_c;
  logic [CNT_W-1:0]  retire_q;

  wb_regfile_load_align #(.DATA_W(DATA_W)) u_load_align (
    .ld_data (bus.ld_data_in),
    .off     (bus.alu_out_in[1:0]),
    .funct3  (bus.wb_funct3),
    .data    (ld_aligned),
    .err     (ld_err)
  );

  assign wb_data_c = (bus.wb_sel == WB_SEL_LD) ? ld_aligned : bus.alu_out_in;

  // Status is forced low during reset, which also disables the bypass path.
  assign err_c    = rst & bus.wb_valid & bus.wb_we & (bus.wb_sel == WB_SEL_LD) & ld_err;
  assign commit_c = rst & bus.wb_valid & bus.wb_we & (bus.wb_rd != '0) & ~err_c;

  assign bus.wb_data    = wb_data_c;
  assign bus.wb_err     = err_c;
  assign bus.wb_commit  = commit_c;
  assign bus.retire_cnt = retire_q;

  // x0 is never written (commit excludes rd==0), so it holds its reset zero.
  assign bus.rs1_data = (bus.rs1_addr == '0) ? '0 :
                        (commit_c && bus.rs1_addr == bus.wb_rd) ? wb_data_c :
                        regs[bus.rs1_addr];
  assign bus.rs2_data = (bus.rs2_addr == '0) ? '0 :
                        (commit_c && bus.rs2_addr == bus.wb_rd) ? wb_data_c :
                        regs[bus.rs2_addr];

  // Architectural register array: cleared on reset, one write per committed instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (commit_c) begin
      regs[bus.wb_rd] <= wb_data_c;
    end
  end

  // Retire counter: every valid WB instruction counts, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              retire_q <= '0;
    else if (bus.wb_valid) retire_q <= retire_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, hand sequences, random vs. reference model.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );
  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mregs [32];
  logic [31:0] mcnt;

  typedef struct {
    logic        v, we, sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, ld;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_err, exp_commit;
  } vec_t;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  // Reference load: {err, data} from plain shifts and arithmetic.
  function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [31:0] ld, input int unsigned off);
    logic [31:0] b, h;
    b = (ld >> (8 * off)) & 32'h0000_00FF;
    h = (ld >> (8 * off)) & 32'h0000_FFFF;
    case (f3)
      3'd0: return {1'b0, (b >= 32'd128) ? b - 32'd256 : b};
      3'd4: return {1'b0, b};
      3'd1: return {(off % 2 != 0), (h >= 32'd32768) ? h - 32'd65536 : h};
      3'd5: return {(off % 2 != 0), h};
      3'd2: return {(off != 0), ld};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic c, input logic [4:0] rd, input logic [31:0] d);
    if (a == 0) return 32'h0;
    if (c && a == rd) return d;
    return mregs[a];
  endfunction

  // One WB cycle: called just after a falling edge, returns just after the next falling edge.
  task automatic run_cycle(input string nm, input int idx,
                           input logic v, we, sel, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] alu, ld, input logic [4:0] rs1, rs2,
                           input logic use_tbl, input vec_t tv);
    logic [32:0] lr;
    logic [31:0] d;
    logic        e, c;
    bus.wb_valid = v; bus.wb_we = we; bus.wb_sel = sel; bus.wb_funct3 = f3;
    bus.wb_rd = rd; bus.alu_out_in = alu; bus.ld_data_in = ld;
    bus.rs1_addr = rs1; bus.rs2_addr = rs2;
    lr = ref_load(f3, ld, int'(alu[1:0]));
    d  = sel ? lr[31:0] : alu;
    e  = v && we && sel && lr[32];
    c  = v && we && (rd != 0) && !e;
    #1;
    if (use_tbl) begin
      e = tv.exp_err; c = tv.exp_commit;
      if (tv.chk_data) d = tv.exp_data;
    end
    chk({nm, ".err"}, idx, 32'(bus.wb_err), 32'(e));
    chk({nm, ".commit"}, idx, 32'(bus.wb_commit), 32'(c));
    if (!(sel && lr[32])) chk({nm, ".wb_data"}, idx, bus.wb_data, d);
    chk({nm, ".rs1"}, idx, bus.rs1_data, ref_read(rs1, c, rd, d));
    chk({nm, ".rs2"}, idx, bus.rs2_data, ref_read(rs2, c, rd, d));
    @(posedge clk);
    #1;
    if (c) mregs[rd] = d;
    if (v) mcnt = mcnt + 32'd1;
    bus.wb_valid = 1'b0; bus.rs2_addr = rd;
    #1;
    chk({nm, ".rd_after"}, idx, bus.rs2_data, (rd == 0) ? 32'h0 : mregs[rd]);
    chk({nm, ".retire"}, idx, bus.retire_cnt, mcnt);
    @(negedge clk);
  endtask

  vec_t tbl [17];
  vec_t nov;

  initial begin
    logic [31:0] ldv;
    int nval;
    ldv = 32'h80FF_7F01;
    nov = '{default: '0};
    foreach (mregs[i]) mregs[i] = 32'h0;
    mcnt = 32'h0;
    bus4.wb_valid = 0; bus4.wb_we = 0; bus4.wb_sel = 0; bus4.wb_funct3 = 0;
    bus4.wb_rd = 0; bus4.alu_out_in = 0; bus4.ld_data_in = 0; bus4.rs1_addr = 0; bus4.rs2_addr = 0;

    //            v  we sel f3    rd  alu            ld    chk data           err commit
    tbl[0]  = '{1, 1, 0, 3'd0, 3,  32'hDEAD_BEEF, 0,    1, 32'hDEAD_BEEF, 0, 1};
    tbl[1]  = '{1, 1, 0, 3'd0, 0,  32'hFFFF_FFFF, 0,    1, 32'hFFFF_FFFF, 0, 0};
    tbl[2]  = '{1, 1, 0, 3'd0, 15, 32'hA5A5_0015, 0,    1, 32'hA5A5_0015, 0, 1};
    tbl[3]  = '{1, 1, 0, 3'd0, 16, 32'hA5A5_0016, 0,    1, 32'hA5A5_0016, 0, 1};
    tbl[4]  = '{1, 1, 0, 3'd0, 17, 32'hA5A5_0017, 0,    1, 32'hA5A5_0017, 0, 1};
    tbl[5]  = '{1, 1, 1, 3'd0, 10, 32'h0000_1003, ldv,  1, 32'hFFFF_FF80, 0, 1};
    tbl[6]  = '{1, 1, 1, 3'd4, 11, 32'h0000_2003, ldv,  1, 32'h0000_0080, 0, 1};
    tbl[7]  = '{1, 1, 1, 3'd1, 12, 32'h0000_2002, ldv,  1, 32'hFFFF_80FF, 0, 1};
    tbl[8]  = '{1, 1, 1, 3'd5, 13, 32'h0000_2000, ldv,  1, 32'h0000_7F01, 0, 1};
    tbl[9]  = '{1, 1, 1, 3'd2, 14, 32'h0000_2000, ldv,  1, 32'h80FF_7F01, 0, 1};
    tbl[10] = '{1, 1, 1, 3'd2, 15, 32'h0000_2002, ldv,  0, 32'h0,         1, 0};
    tbl[11] = '{1, 1, 1, 3'd1, 16, 32'h0000_2001, ldv,  0, 32'h0,         1, 0};
    tbl[12] = '{1, 1, 1, 3'd3, 17, 32'h0000_2000, ldv,  0, 32'h0,         1, 0};
    tbl[13] = '{0, 1, 1, 3'd2, 15, 32'h0000_2002, ldv,  0, 32'h0,         0, 0};
    tbl[14] = '{0, 1, 1, 3'd1, 16, 32'h0000_2001, ldv,  0, 32'h0,         0, 0};
    tbl[15] = '{0, 1, 1, 3'd3, 17, 32'h0000_2000, ldv,  0, 32'h0,         0, 0};
    tbl[16] = '{1, 0, 0, 3'd0, 3,  32'h0000_0001, 0,    1, 32'h0000_0001, 0, 0};

    // Reset held with an otherwise committing (and erroring-capable) instruction present.
    bus.wb_valid = 1; bus.wb_we = 1; bus.wb_sel = 1; bus.wb_funct3 = 3'd3; bus.wb_rd = 5;
    bus.alu_out_in = 32'h1234; bus.ld_data_in = 0; bus.rs1_addr = 5; bus.rs2_addr = 5;
    repeat (2) @(negedge clk);
    chk("rst.rs1", 0, bus.rs1_data, 32'h0);
    chk("rst.retire", 0, bus.retire_cnt, 32'h0);
    chk("rst.err", 0, 32'(bus.wb_err), 32'h0);
    bus.wb_sel = 0;
    #1;
    chk("rst.commit", 0, 32'(bus.wb_commit), 32'h0);
    chk("rst.rs2", 0, bus.rs2_data, 32'h0);
    bus.wb_valid = 0;
    rst = 1'b1;

    // Directed vectors; rs1 tracks rd so the bypass path is exercised.
    for (int i = 0; i < 17; i++)
      run_cycle("tbl", i, tbl[i].v, tbl[i].we, tbl[i].sel, tbl[i].f3, tbl[i].rd,
                tbl[i].alu, tbl[i].ld, tbl[i].rd, 5'd3, 1'b1, tbl[i]);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] f3;
      logic [4:0] rd;
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      run_cycle("rnd", i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom), f3, rd, $urandom, $urandom,
                ($urandom_range(0, 1) != 0) ? rd : 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 1'b0, nov);
    end

    // Asynchronous reset mid-run after x5 is written.
    run_cycle("x5", 0, 1, 1, 0, 3'd0, 5, 32'h1234, 0, 5, 5, 1'b0, nov);
    bus.wb_valid = 0; bus.rs1_addr = 5;
    #2;
    chk("mid.pre", 0, bus.rs1_data, 32'h1234);
    rst = 1'b0;
    #1;
    chk("mid.rs1", 0, bus.rs1_data, 32'h0);
    chk("mid.retire", 0, bus.retire_cnt, 32'h0);
    foreach (mregs[i]) mregs[i] = 32'h0;
    mcnt = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    run_cycle("post", 0, 1, 1, 0, 3'd0, 7, 32'h0BAD_F00D, 0, 7, 5, 1'b0, nov);
    chk("post.x7", 0, mregs[7], 32'h0BAD_F00D);

    // 4-bit counter wraps after 16 valid cycles; idle cycles do not count.
    chk("wrap.start", 0, 32'(bus4.retire_cnt), 32'h0);
    nval = 0;
    for (int i = 0; nval < 17; i++) begin
      bus4.wb_valid = (i % 4 != 3);
      @(posedge clk);
      #1;
      if (bus4.wb_valid) nval++;
      if (nval == 15 || nval == 16) chk("wrap.mid", nval, 32'(bus4.retire_cnt), 32'(nval % 16));
      @(negedge clk);
    end
    bus4.wb_valid = 0;
    chk("wrap.17", 0, 32'(bus4.retire_cnt), 32'h1);
    repeat (3) @(negedge clk);
    chk("wrap.idle", 0, 32'(bus4.retire_cnt), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus architectural register file. Sits directly downstream of the MEM/WB pipeline register and consumes its latched ALU result and load data.
- Aligns and extends load data, selects the writeback value and commits it to a 32x32 register file with x0 hardwired to zero.
- Serves the decode stage through two combinational read ports with write-through bypass, and counts retired writebacks.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- wb_valid  in  1  instruction in WB stage is valid.
- wb_we  in  1  instruction writes rd.
- wb_sel  in  1  0 = ALU result, 1 = load data.
- wb_funct3  in  3  load width/sign code.
- wb_rd  in  ADDR_W  destination register.
- alu_out_in  in  DATA_W  ALU result; [1:0] is the load byte offset.
- ld_data_in  in  DATA_W  raw word read from data memory.
- rs1_addr  in  ADDR_W  read port 1 index.
- rs2_addr  in  ADDR_W  read port 2 index.
- rs1_data  out  DATA_W  read port 1 data.
- rs2_data  out  DATA_W  read port 2 data.
- wb_data  out  DATA_W  selected writeback value, to forwarding.
- wb_commit  out  1  a register write happens this cycle.
- wb_err  out  1  misaligned or illegal load in WB this cycle.
- retire_cnt  out  CNT_W  count of valid instructions retired.

Behaviour:
- Reset (rst==0, async):
  - All registers 0 and retire_cnt 0.
  - Read ports return 0.
  - wb_commit and wb_err are driven 0 while rst is low.
  - Reset deasserted mid-stream: the first rising edge after release performs normal operation.
- Load alignment (combinational, off = alu_out_in[1:0]):
  - 000 LB: sign-extended ld_data byte[off].
  - 100 LBU: zero-extended ld_data byte[off].
  - 001 LH: sign-extended halfword at off; requires off[0]==0.
  - 101 LHU: zero-extended halfword at off; requires off[0]==0.
  - 010 LW: full word; requires off==0.
  - Byte lanes are little-endian: byte k = ld_data_in[8k+7:8k].
  - Any other funct3, or an alignment violation, is a load error.
- wb_data = wb_sel ? aligned load : alu_out_in. It is computed regardless of wb_valid.
- wb_err = wb_valid & wb_we & wb_sel & load error.
- wb_commit = wb_valid & wb_we & (wb_rd != 0) & ~wb_err.
- Write: on a rising edge with wb_commit=1, reg[wb_rd] <= wb_data. Otherwise no register changes. Writes to x0 are dropped.
- Read (combinational):
  - rsN_data = 0 if rsN_addr==0.
  - Else wb_data if wb_commit and rsN_addr==wb_rd (write-through bypass).
  - Else reg[rsN_addr].
  - Both ports may address the same register.
- retire_cnt:
  - Increments by 1 on each rising edge with wb_valid=1, including x0 writes, non-writing instructions and errored loads.
  - Wraps modulo 2**CNT_W with no saturation.
- Latency: write visible at read ports in the same cycle via bypass, and from the array from the next cycle.

Decomposition:
- Shared package (pipeline-wide):
  - funct3 load codes: LB, LH, LW, LBU, LHU.
  - WB_SEL_ALU / WB_SEL_LD constants.
  - DATA_W / ADDR_W defaults.
- One sub-module, load_align (combinational): ld_data, off, funct3 -> aligned data, err. It is reused by any later load-forwarding logic.

Test Plan:
- Reset: hold rst=0, then release. rs1_addr=5 -> rs1_data=0; retire_cnt=0. Assert rst=0 mid-run after writing x5=0x1234 -> x5 reads 0 immediately, asynchronously.
- ALU write plus bypass: valid, we, sel=0, rd=3, alu_out=0xDEADBEEF, rs1_addr=3 in the same cycle -> rs1_data=0xDEADBEEF before the edge; after the edge rs2_addr=3 also reads 0xDEADBEEF; retire_cnt=1.
- x0 protection: valid, we, rd=0, alu_out=0xFFFFFFFF -> wb_commit=0, rs1_addr=0 reads 0, retire_cnt still increments.
- Load extension with ld_data=0x80FF7F01:
  - LB at off=3 -> 0xFFFFFF80.
  - LBU at off=3 -> 0x00000080.
  - LH at off=2 -> 0xFFFF80FF.
  - LHU at off=0 -> 0x00007F01.
  - LW at off=0 -> 0x80FF7F01.
  - Each is written to a distinct rd and read back.
- Misaligned/illegal loads:
  - LW at off=2, LH at off=1, or funct3=011 -> wb_err=1, wb_commit=0, rd unchanged, retire_cnt increments.
  - Same cases with wb_valid=0 -> wb_err=0.
- Counter wrap: with CNT_W=4, apply 17 valid cycles -> retire_cnt=1. Cycles with wb_valid=0 do not increment.
